// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter; drives ps2_clk/ps2_data low via output enables only.
// Define PS2_TX_RETRY_EN to retry a failed frame up to RETRY_MAX extra times.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int SETUP_CYCLES   = 20,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000,
    parameter int FILTER_LEN     = 8,
    parameter int RETRY_MAX      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    localparam int M1   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int M2   = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int TMAX = (M1 > M2) ? M1 : M2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int RW   = $clog2(RETRY_MAX + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SETUP,
        S_WAIT_FIRST,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } state_t;

    state_t         state_q, state_d;
    logic           clk_s1_q, clk_s2_q;
    logic           dat_s1_q, dat_s2_q;
    logic           clk_f_q, clk_f_d;
    logic           clk_fp_q;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic           fall;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [9:0]     shift_q, shift_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic           dbit_q, dbit_d;
    logic           ack_q, ack_d;
    logic [1:0]     err_code_q, err_code_d;
    logic           done_q, done_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           fail_req;
    logic [1:0]     fail_code;
    logic           xfer_exp;

    // Synchronizers and ps2_clk glitch filter; idle lines read as high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            clk_f_q  <= 1'b1;
            clk_fp_q <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_in;
            dat_s2_q <= dat_s1_q;
            clk_f_q  <= clk_f_d;
            clk_fp_q <= clk_f_q;
            fcnt_q   <= fcnt_d;
        end
    end

    always_comb begin
        clk_f_d = clk_f_q;
        fcnt_d  = '0;
        if (clk_s2_q != clk_f_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                clk_f_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall     = clk_fp_q & ~clk_f_q;
    assign xfer_exp = (tmr_q == TW'(XFER_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            dbit_q     <= 1'b0;
            ack_q      <= 1'b1;
            err_code_q <= 2'b00;
            done_q     <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            dbit_q     <= dbit_d;
            ack_q      <= ack_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
            retry_q    <= retry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        dbit_d     = dbit_q;
        ack_d      = ack_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        retry_d    = retry_q;
        fail_req   = 1'b0;
        fail_code  = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    retry_d = '0;
                    tmr_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmr_q == TW'(INHIBIT_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SETUP: begin
                if (tmr_q == TW'(SETUP_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT_FIRST;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT_FIRST: begin
                // A fall coinciding with expiry wins over the timeout.
                if (fall) begin
                    dbit_d    = ~shift_q[0];
                    bit_cnt_d = 4'd1;
                    tmr_d     = '0;
                    state_d   = S_SEND;
                end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
                    fail_req  = 1'b1;
                    fail_code = 2'b01;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SEND: begin
                tmr_d = tmr_q + 1'b1;
                if (fall) begin
                    if (bit_cnt_q == 4'd10) begin
                        ack_d   = dat_s2_q;
                        state_d = S_ACK;
                    end else begin
                        dbit_d    = ~shift_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (xfer_exp) begin
                    fail_req  = 1'b1;
                    fail_code = 2'b10;
                end
            end
            S_ACK: begin
                tmr_d = tmr_q + 1'b1;
                if (ack_q) begin
                    fail_req  = 1'b1;
                    fail_code = 2'b11;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_f_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (xfer_exp) begin
                    fail_req  = 1'b1;
                    fail_code = 2'b10;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail_req) begin
            tmr_d  = '0;
            dbit_d = 1'b0;
            if (RetryEn && (retry_q < RW'(RETRY_MAX))) begin
                retry_d = retry_q + 1'b1;
                state_d = S_INHIBIT;
            end else begin
                err_code_d = fail_code;
                state_d    = S_FAIL;
            end
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ps2_clk_oe  = (state_q == S_INHIBIT) | (state_q == S_SETUP);
    assign ps2_data_oe = (state_q == S_SETUP) | (state_q == S_WAIT_FIRST) |
                         (((state_q == S_SEND) | (state_q == S_ACK)) & dbit_q);
    assign tx_done     = done_q;
    assign tx_err      = (state_q == S_FAIL);
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on open-collector lines, scoreboard of
// expected done/err responses and device-captured frames.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .SETUP_CYCLES  (4),
        .START_TIMEOUT (2000),
        .XFER_TIMEOUT  (5000),
        .FILTER_LEN    (8),
        .RETRY_MAX     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          err_cyc = 0;
    int          oecnt = 0;
    int          frames = 0;
    logic        prev_oe = 1'b0;
    logic [1:0]  oe_at_err = 2'b11;
    logic [10:0] cap = '0;
    logic [2:0]  exp_q[$];
    logic [10:0] frm_q[$];

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Response monitor: {err, code}; a done expects 3'b000 plus a frame.
    always @(negedge clk) begin
        logic [2:0]  e;
        logic [2:0]  g;
        logic [10:0] f;
        cyc++;
        if (ps2_clk_oe) oecnt++;
        if (ps2_clk_oe && !prev_oe) frames++;
        if (!ps2_clk_oe && prev_oe) rel_cyc = cyc;
        prev_oe = ps2_clk_oe;
        if (!rst && (tx_done || tx_err)) begin
            if (tx_err) begin
                err_cyc   = cyc;
                oe_at_err = {ps2_clk_oe, ps2_data_oe};
            end
            g = tx_err ? {1'b1, err_code} : 3'b000;
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", int'(g), -1);
            end else begin
                e = exp_q.pop_front();
                chk("resp", int'(g), int'(e));
                if (e == 3'b000 && frm_q.size() != 0) begin
                    f = frm_q.pop_front();
                    if (tx_done) chk("frame", int'(cap), int'(f));
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && t < 50000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("resp_pending", exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    // Device: the clock release is the first rising edge (start bit),
    // then falls 1..10 with samples on rises; fall 11 is the ACK slot.
    task automatic dev_frame(input int nf, input bit ack);
        int t = 0;
        while (clk_line && t < 5000) begin
            @(negedge clk);
            t++;
        end
        while (!clk_line && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("dev_release_seen", int'(t < 5000), 1);
        if (t < 5000) begin
            repeat (5) @(negedge clk);
            cap    = '0;
            cap[0] = data_line;
            repeat (15) @(negedge clk);
            for (int i = 1; i <= nf; i++) begin
                if (i == 11 && ack) dev_data_low = 1'b1;
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b0;
                if (i <= 10) cap[i] = data_line;
                repeat (20) @(negedge clk);
                dev_data_low = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_oe;
        int base_fr;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("rst_pulses", int'({tx_done, tx_err}), 0);
        chk("rst_err_code", int'(err_code), 0);

        // 0xED: start,d0..d7,parity,stop = 0,1,0,1,1,0,1,1,1,1,1
        base_oe = oecnt;
        base_fr = frames;
        exp_q.push_back(3'b000);
        frm_q.push_back(11'h7DA);
        fork
            send(8'hED);
            dev_frame(11, 1'b1);
        join
        wait_resp();
        chk("clk_oe_cycles", oecnt - base_oe, 104);
        chk("frames_ed", frames - base_fr, 1);
        chk("ready_after_done", int'(tx_ready), 1);
        chk("busy_after_done", int'(busy), 0);

        // 0xF4 -> parity 0; 0x00 -> parity 1
        exp_q.push_back(3'b000);
        frm_q.push_back(11'h5E8);
        fork
            send(8'hF4);
            dev_frame(11, 1'b1);
        join
        wait_resp();
        exp_q.push_back(3'b000);
        frm_q.push_back(11'h600);
        fork
            send(8'h00);
            dev_frame(11, 1'b1);
        join
        wait_resp();

`ifndef PS2_TX_RETRY_EN
        // Device silent: start timeout 2000 cycles after release.
        exp_q.push_back(3'b101);
        send(8'hF4);
        wait_resp();
        chk("start_timeout_lat", err_cyc - rel_cyc, 2000);
        chk("oe_at_start_err", int'(oe_at_err), 0);

        // Device stops after 5 falls -> transfer timeout.
        exp_q.push_back(3'b110);
        fork
            send(8'h3C);
            dev_frame(5, 1'b0);
        join
        wait_resp();
        chk("oe_at_xfer_err", int'(oe_at_err), 0);

        // Data left high at fall 11 -> no ACK.
        exp_q.push_back(3'b111);
        fork
            send(8'hED);
            dev_frame(11, 1'b0);
        join
        wait_resp();
        repeat (20) @(negedge clk);
        chk("err_code_hold", int'(err_code), 3);
        chk("ready_after_err", int'(tx_ready), 1);
`endif

        // Reset in the middle of SEND (after fall 4, d3 of 0xA5 is 0).
        fork
            send(8'hA5);
            dev_frame(4, 1'b0);
        join
        chk("pre_rst_data_oe", int'(ps2_data_oe), 1);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("post_rst_ready", int'(tx_ready), 1);
        repeat (50) @(negedge clk);

        // 0xFF with a stray tx_valid pulse while busy.
        base_fr = frames;
        exp_q.push_back(3'b000);
        frm_q.push_back(11'h7FE);
        fork
            send(8'hFF);
            dev_frame(11, 1'b1);
            begin
                repeat (60) @(negedge clk);
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_resp();
        repeat (200) @(negedge clk);
        chk("frames_busy_pulse", frames - base_fr, 1);
        chk("ready_idle_end", int'(tx_ready), 1);

`ifdef PS2_TX_RETRY_EN
        // NACK twice, then ACK: three attempts, single tx_done.
        base_fr = frames;
        exp_q.push_back(3'b000);
        frm_q.push_back(11'h5E8);
        fork
            send(8'hF4);
            begin
                dev_frame(11, 1'b0);
                dev_frame(11, 1'b0);
                dev_frame(11, 1'b1);
            end
        join
        wait_resp();
        chk("retry_inhibits", frames - base_fr, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED set-LEDs, 0xFF reset, and 0xF4 enable. It is the opposite direction of the existing PS2 keyboard receiver and shares the same ps2_clk/ps2_data open-collector pins. It drives the lines low through output-enables only and never drives them high. It exports busy so the receiver can ignore line activity during transmission.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles ps2_clk is held low before the start bit (100 us at 100 MHz).
SETUP_CYCLES, 20, cycles data and clk are both held low before ps2_clk is released.
START_TIMEOUT, 1500000, maximum cycles from ps2_clk release to the first device falling edge (15 ms).
XFER_TIMEOUT, 200000, maximum cycles from the first falling edge to the ACK falling edge (2 ms).
FILTER_LEN, 8, consecutive equal synchronized samples required to accept a new ps2_clk level.
RETRY_MAX, 2, extra attempts allowed (used only with the optional feature).

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high in IDLE only
ps2_clk_in  in  1  raw ps2_clk pin level
ps2_data_in  in  1  raw ps2_data pin level
ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release
ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse on successful ACK
tx_err  out  1  one-cycle pulse on failure
err_code  out  2  valid with tx_err: 01 start timeout, 10 transfer timeout, 11 no ACK; holds its last value otherwise

Behaviour:
- Reset (sync, active-high; applies mid-frame too): state IDLE, both oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0, err_code=00, counters 0. Lines are released on the cycle after rst is sampled high.
- Input path: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer. ps2_clk then goes through a FILTER_LEN glitch filter. A falling edge (fall) is a one-cycle strobe when the filtered level goes 1->0.
- Accept rule: tx_valid && tx_ready. tx_data is latched as shift register {stop=1, parity, data}, where parity = ~^tx_data (odd parity). tx_valid outside IDLE is ignored.
- IDLE: wait for accept, then go to INHIBIT. On the next cycle ps2_clk_oe=1, tx_ready=0, busy=1.
- INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to SETUP.
- SETUP: clk_oe=1 and data_oe=1 (start bit 0) for SETUP_CYCLES cycles. Then clk_oe=0 and go to WAIT_FIRST.
- WAIT_FIRST: data_oe stays 1. The timer runs from the first WAIT_FIRST cycle. A fall goes to SEND with bit_cnt=0 and the XFER timer cleared. A timer value of START_TIMEOUT goes to FAIL with code 01.
- SEND: each fall, including the one that entered SEND, sets data_oe = ~shift[bit_cnt] and then increments bit_cnt.
  - Falls 1-8 send d0..d7, fall 9 sends parity, fall 10 sends stop (data_oe=0).
  - At fall 11 go to ACK.
- ACK: sample synchronized ps2_data on the fall-11 cycle. 0 goes to WAIT_IDLE; 1 goes to FAIL with code 11.
- WAIT_IDLE: once filtered clk and synchronized data are both 1, pulse tx_done and go to IDLE.
- XFER timer: counts from the entry into SEND through ACK. Reaching XFER_TIMEOUT goes to FAIL with code 10; this covers a device that stops clocking. The check also applies in WAIT_IDLE.
- FAIL: both oe=0, pulse tx_err with err_code for 1 cycle, then go to IDLE.
- Simultaneous events: a fall in the same cycle the timer expires counts as the fall; the timeout is not taken.
- Line ownership: clk_oe is never 1 outside INHIBIT/SETUP. data_oe is never 1 in IDLE, FAIL, or WAIT_IDLE.

Optional Feature:
PS2_TX_RETRY_EN.
- Defined: any failure restarts at INHIBIT with the same latched byte, up to RETRY_MAX times. tx_err and err_code are reported only after the final attempt fails. busy stays high across retries.
- Undefined: a single attempt; every failure reports immediately. RETRY_MAX is unused.

Test Plan:
All tests use INHIBIT_CYCLES=100, SETUP_CYCLES=4, START_TIMEOUT=2000, XFER_TIMEOUT=5000, and a bench device model with a 40-cycle clock period.
1. Send 0xED, device ACKs -> bits sampled on device rising edges are 0,1,0,1,1,0,1,1,1,1,1; clk_oe is high for exactly 104 cycles; tx_done pulses once; tx_ready returns to 1.
2. Send 0xF4 -> parity bit 0; send 0x00 -> parity bit 1; both complete with tx_done.
3. Device never clocks -> tx_err with err_code=01 exactly 2000 cycles after clk release; both oe=0.
4. Device stops after 5 falls -> tx_err with err_code=10; device leaves data high at fall 11 -> err_code=11.
5. Assert rst during SEND bit 4 -> both oe=0 and tx_ready=1 the next cycle; a following send of 0xFF completes normally. A tx_valid pulse while busy causes no second frame.
6. With PS2_TX_RETRY_EN and RETRY_MAX=2, NACK twice then ACK -> 3 INHIBIT phases, no tx_err, a single tx_done.
